// File: rtl/ps2_rx_frontend.sv
// rtl/ps2_rx_frontend.sv - PS/2 receive front end: sync, clock filter, frame deserializer, prefix folding, code FIFO.
// Optional clock glitch filter enabled by defining PS2_RX_FILTER_EN.
module ps2_rx_frontend #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000,
  parameter int FIFO_AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               rx_read,
  input  logic               ovf_clr,
  output logic [7:0]         rx_scan_code,
  output logic               rx_extended,
  output logic               rx_released,
  output logic               rx_data_ready,
  output logic               rx_frame_error,
  output logic               rx_overflow,
  output logic [FIFO_AW:0]   rx_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  if (FILTER_LEN < 2 || FILTER_LEN > 16) begin : g_bad_filter_len
    $error("FILTER_LEN must be within 2..16");
  end

  // Both pins are asynchronous; idle bus level is high.
  logic clk_s1, clk_s2, dat_s1, dat_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  logic clk_filt;
  logic clk_filt_q;

`ifdef PS2_RX_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] flt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_s2 == clk_filt) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_s2;
      flt_cnt  <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end
`else
  assign clk_filt = clk_s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) clk_filt_q <= 1'b1;
    else     clk_filt_q <= clk_filt;
  end

  logic fall;
  assign fall = clk_filt_q & ~clk_filt;

  logic [1:0]    state;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] to_cnt;
  logic          ext_f, rel_f;
  logic          frame_err;

  logic stop_edge, frame_done, frame_bad, is_prefix, push;
  assign stop_edge  = fall && (state == S_STOP);
  assign frame_done = stop_edge && dat_s2 && par_ok;
  assign frame_bad  = stop_edge && !(dat_s2 && par_ok);
  assign is_prefix  = (shreg == 8'hE0) || (shreg == 8'hF0);
  assign push       = frame_done && !is_prefix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      par_ok    <= 1'b0;
      to_cnt    <= '0;
      ext_f     <= 1'b0;
      rel_f     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_bad;

      if (state == S_IDLE || fall) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (fall && !dat_s2) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (fall) begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (fall) begin
            par_ok <= ^{dat_s2, shreg};
            state  <= S_STOP;
          end
        end
        default: begin
          if (fall) begin
            state <= S_IDLE;
            if (frame_done && shreg == 8'hE0) begin
              ext_f <= 1'b1;
            end else if (frame_done && shreg == 8'hF0) begin
              rel_f <= 1'b1;
            end else begin
              ext_f <= 1'b0;
              rel_f <= 1'b0;
            end
          end
        end
      endcase

      // A stalled device abandons the partial byte but keeps pending prefixes.
      if (state != S_IDLE && !fall && to_cnt == TW'(TIMEOUT - 1)) state <= S_IDLE;
    end
  end

  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               rd_q;
  logic               ovf;

  logic full, empty, pop, do_push, ovf_set;
  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = rx_read && !rd_q && !empty;
  assign do_push = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {ext_f, rel_f, shreg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_q   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      rd_q <= rx_read;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  logic [9:0] head;
  assign head = mem[rd_ptr];

  assign rx_scan_code   = empty ? 8'h00 : head[7:0];
  assign rx_released    = empty ? 1'b0  : head[8];
  assign rx_extended    = empty ? 1'b0  : head[9];
  assign rx_data_ready  = !empty;
  assign rx_frame_error = frame_err;
  assign rx_overflow    = ovf;
  assign rx_count       = count;

endmodule
